// File: rtl/spi_slave_rtl_engine_if.sv
// spi_slave_rtl_engine_if: SPI pins plus TX/RX word streams between master side and slave engine
interface spi_slave_rtl_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic cs_n;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport slave (
    input cs_n, sclk, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid
  );
  modport master (
    output cs_n, sclk, mosi, tx_data, tx_valid, rx_ready,
    input miso, miso_oe, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_rtl_engine.sv
// spi_slave_rtl_engine: oversampled SPI slave (all CPOL/CPHA modes), RX FIFO, TX holding reg; SPI_SLV_STATUS_CNT_EN adds status counters
module spi_slave_rtl_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic pclk,
  input logic areset,
  input logic cpol,
  input logic cpha,
  spi_slave_rtl_engine_if.slave bus,
  output logic rx_overflow,
  output logic tx_underrun,
  output logic frame_err,
  output logic busy
`ifdef SPI_SLV_STATUS_CNT_EN
  ,
  output logic [15:0] ovf_count,
  output logic [15:0] urun_count,
  output logic [15:0] ferr_count
`endif
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, tx_reg_q, tx_reg_d;
  logic tx_full_q, tx_full_d, urun_pend_q, urun_pend_d;
  logic miso_q, miso_d, oe_q, oe_d;
  logic ovf_q, ovf_d, urun_q, urun_d, ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] mem_q [RX_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RX_FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic sclk_s, cs_s, mosi_s, act, edge_s, lead, trail, smp, shf, word_done;
  logic empty, full, pop, push_ok;
  logic [DATA_WIDTH-1:0] rx_word;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign act = state_q == ACTIVE && !cs_s;
  assign edge_s = act && sclk_s != sclk_prev_q;
  assign lead = edge_s && sclk_s != cpol_q;
  assign trail = edge_s && sclk_s == cpol_q;
  assign smp = cpha_q ? trail : lead;
  assign shf = (cpha_q ? lead : trail) && bit_cnt_q != '0;
  assign word_done = smp && bit_cnt_q == CNT_LAST;
  assign rx_word = {rx_sr_q, mosi_s};
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign pop = !empty && bus.rx_ready;
  assign push_ok = word_done && (!full || pop);
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d = cs_s;
    state_d = state_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d = rx_sr_q;
    tx_sr_d = shf ? {tx_sr_q[DATA_WIDTH-2:0], 1'b0} : tx_sr_q;
    tx_reg_d = bus.tx_valid && !tx_full_q ? bus.tx_data : tx_reg_q;
    tx_full_d = tx_full_q ? !(state_q == LOAD || word_done) : bus.tx_valid;
    urun_pend_d = urun_pend_q;
    oe_d = oe_q;
    ovf_d = word_done && full && !pop;
    urun_d = 1'b0;
    ferr_d = 1'b0;
    mem_d = mem_q;
    wr_d = push_ok ? wr_q + PTR_ONE : wr_q;
    rd_d = pop ? rd_q + PTR_ONE : rd_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = rx_word;
    if (lead && urun_pend_q) begin
      urun_d = 1'b1;
      urun_pend_d = 1'b0;
    end
    if (smp) begin
      rx_sr_d = rx_word[DATA_WIDTH-2:0];
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_ONE;
    end
    if (word_done) begin
      tx_sr_d = tx_full_q ? tx_reg_q : '0;
      urun_pend_d = !tx_full_q;
    end
    if (state_q == IDLE && cs_prev_q && !cs_s) state_d = LOAD;
    if (state_q == LOAD) begin
      state_d = ACTIVE;
      cpol_d = cpol;
      cpha_d = cpha;
      bit_cnt_d = '0;
      oe_d = 1'b1;
      tx_sr_d = tx_full_q ? tx_reg_q : '0;
      urun_d = !tx_full_q;
    end
    if (state_q == ACTIVE && cs_s) begin
      state_d = IDLE;
      oe_d = 1'b0;
      tx_sr_d = '0;
      ferr_d = bit_cnt_q != '0;
      bit_cnt_d = '0;
      urun_pend_d = 1'b0;
    end
    miso_d = oe_d && tx_sr_d[DATA_WIDTH-1];
  end
  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_sync_q <= '0;
      cs_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q <= 1'b0;
      state_q <= IDLE;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      bit_cnt_q <= '0;
      rx_sr_q <= '0;
      tx_sr_q <= '0;
      tx_reg_q <= '0;
      tx_full_q <= 1'b0;
      urun_pend_q <= 1'b0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      ovf_q <= 1'b0;
      urun_q <= 1'b0;
      ferr_q <= 1'b0;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q <= cs_prev_d;
      state_q <= state_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
      tx_reg_q <= tx_reg_d;
      tx_full_q <= tx_full_d;
      urun_pend_q <= urun_pend_d;
      miso_q <= miso_d;
      oe_q <= oe_d;
      ovf_q <= ovf_d;
      urun_q <= urun_d;
      ferr_q <= ferr_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  assign bus.miso = miso_q;
  assign bus.miso_oe = oe_q;
  assign bus.tx_ready = !tx_full_q;
  assign bus.rx_valid = !empty;
  assign bus.rx_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign rx_overflow = ovf_q;
  assign tx_underrun = urun_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
`ifdef SPI_SLV_STATUS_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d, urun_cnt_q, urun_cnt_d, ferr_cnt_q, ferr_cnt_d;
  always_comb begin
    ovf_cnt_d = ovf_cnt_q + 16'(ovf_q && ovf_cnt_q != 16'hFFFF);
    urun_cnt_d = urun_cnt_q + 16'(urun_q && urun_cnt_q != 16'hFFFF);
    ferr_cnt_d = ferr_cnt_q + 16'(ferr_q && ferr_cnt_q != 16'hFFFF);
  end
  always_ff @(posedge pclk) begin
    if (areset) begin
      ovf_cnt_q <= '0;
      urun_cnt_q <= '0;
      ferr_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      urun_cnt_q <= urun_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end
  assign ovf_count = ovf_cnt_q;
  assign urun_count = urun_cnt_q;
  assign ferr_count = ferr_cnt_q;
`endif
endmodule

// File: tb/tb_spi_slave_rtl_engine.sv
// tb_spi_slave_rtl_engine: bit-banged SPI master with vector table and RX scoreboard for spi_slave_rtl_engine
module tb_spi_slave_rtl_engine;
  localparam int DW = 8;
  localparam int H = 8;
  typedef struct {
    logic cpol;
    logic cpha;
    logic [DW-1:0] mo;
    logic [DW-1:0] tx;
    logic [DW-1:0] exp_rx;
    logic [DW-1:0] exp_mi;
  } vec_t;
  logic pclk = 1'b0;
  logic areset = 1'b1;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic rx_overflow, tx_underrun, frame_err, busy;
`ifdef SPI_SLV_STATUS_CNT_EN
  logic [15:0] ovf_count, urun_count, ferr_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int n_ovf = 0;
  int n_urun = 0;
  int n_ferr = 0;
  logic [DW-1:0] exp_q[$];
  logic m_cpol = 1'b0;
  logic m_cpha = 1'b0;
  vec_t tbl[4];
  spi_slave_rtl_engine_if #(.DATA_WIDTH(DW)) bus();
  spi_slave_rtl_engine #(.DATA_WIDTH(DW), .RX_FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .pclk(pclk),
    .areset(areset),
    .cpol(cpol),
    .cpha(cpha),
    .bus(bus.slave),
    .rx_overflow(rx_overflow),
    .tx_underrun(tx_underrun),
    .frame_err(frame_err),
    .busy(busy)
`ifdef SPI_SLV_STATUS_CNT_EN
    ,
    .ovf_count(ovf_count),
    .urun_count(urun_count),
    .ferr_count(ferr_count)
`endif
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge pclk) begin
    #2;
    if (!areset) begin
      if (rx_overflow) n_ovf++;
      if (tx_underrun) n_urun++;
      if (frame_err) n_ferr++;
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_extra: unexpected word 0x%0h popped", bus.rx_data);
        end else chk("sb_rx", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask
  task automatic frame_begin(input logic pl, input logic ph);
    m_cpol = pl;
    m_cpha = ph;
    cpol = pl;
    cpha = ph;
    bus.sclk = pl;
    bus.cs_n = 1'b1;
    cyc(H);
    bus.cs_n = 1'b0;
    cyc(H);
  endtask
  task automatic frame_end();
    cyc(H);
    bus.cs_n = 1'b1;
    cyc(H);
  endtask
  task automatic xfer(input logic [DW-1:0] mo, input int nb, output logic [DW-1:0] mi);
    mi = '0;
    for (int i = DW - 1; i >= DW - nb; i--) begin
      if (!m_cpha) begin
        bus.mosi = mo[i];
        cyc(H);
        mi[i] = bus.miso;
        bus.sclk = ~m_cpol;
        cyc(H);
        bus.sclk = m_cpol;
      end else begin
        bus.sclk = ~m_cpol;
        bus.mosi = mo[i];
        cyc(H);
        mi[i] = bus.miso;
        bus.sclk = m_cpol;
        cyc(H);
      end
    end
  endtask
  task automatic preload(input logic [DW-1:0] v);
    bus.tx_data = v;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    chk("tx_ready_drop", 32'(bus.tx_ready), 0);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_miso"}, 32'(bus.miso), 0);
    chk({tag, "_miso_oe"}, 32'(bus.miso_oe), 0);
    chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 0);
    chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pulses"}, {29'd0, rx_overflow, tx_underrun, frame_err}, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [DW-1:0] mi;
    logic [DW-1:0] words[5];
    int o, u, f, got;
    tbl[0] = '{cpol: 1'b0, cpha: 1'b0, mo: 8'h3C, tx: 8'hA5, exp_rx: 8'h3C, exp_mi: 8'hA5};
    tbl[1] = '{cpol: 1'b0, cpha: 1'b1, mo: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_mi: 8'h7E};
    tbl[2] = '{cpol: 1'b1, cpha: 1'b0, mo: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_mi: 8'h7E};
    tbl[3] = '{cpol: 1'b1, cpha: 1'b1, mo: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_mi: 8'h7E};
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;
    cyc(4);
    chk_idle("reset");
    areset = 1'b0;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      o = n_ovf;
      u = n_urun;
      f = n_ferr;
      preload(tbl[i].tx);
      frame_begin(tbl[i].cpol, tbl[i].cpha);
      exp_q.push_back(tbl[i].exp_rx);
      xfer(tbl[i].mo, DW, mi);
      frame_end();
      chk($sformatf("vec%0d_miso_word", i), 32'(mi), 32'(tbl[i].exp_mi));
      chk($sformatf("vec%0d_err_pulses", i), n_ovf - o + n_urun - u + n_ferr - f, 0);
      chk($sformatf("vec%0d_tx_ready", i), 32'(bus.tx_ready), 1);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end
    bus.rx_ready = 1'b0;
    o = n_ovf;
    frame_begin(1'b0, 1'b0);
    for (int w = 0; w < 5; w++) begin
      xfer(words[w], DW, mi);
      if (w < 4) exp_q.push_back(words[w]);
    end
    frame_end();
    chk("ovf_pulse_count", n_ovf - o, 1);
    chk("ovf_rx_valid", 32'(bus.rx_valid), 1);
    chk("ovf_head", 32'(bus.rx_data), 32'h11);
    bus.rx_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc(1);
    chk("ovf_drain", exp_q.size(), 0);
    cyc(2);
    chk("ovf_empty", 32'(bus.rx_valid), 0);
    u = n_urun;
    frame_begin(1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    xfer(8'h5A, DW, mi);
    frame_end();
    chk("urun_pulse_count", n_urun - u, 1);
    chk("urun_miso_zero", 32'(mi), 0);
    chk("urun_tx_ready", 32'(bus.tx_ready), 1);
    preload(8'hC3);
    f = n_ferr;
    got = 0;
    frame_begin(1'b0, 1'b0);
    xfer(8'hFF, 3, mi);
    cyc(H);
    bus.cs_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (frame_err) begin
        got = 1;
        chk("ferr_busy", 32'(busy), 0);
        chk("ferr_miso_oe", 32'(bus.miso_oe), 0);
        break;
      end
    end
    chk("ferr_seen", got, 1);
    cyc(H);
    chk("ferr_pulse_count", n_ferr - f, 1);
    chk("ferr_no_push", 32'(bus.rx_valid), 0);
    preload(8'h96);
    frame_begin(1'b1, 1'b1);
    xfer(8'hF0, 3, mi);
    areset = 1'b1;
    cyc(3);
    areset = 1'b0;
    cyc(2 * H);
    chk_idle("midreset");
    preload(8'h69);
    frame_begin(1'b1, 1'b0);
    exp_q.push_back(8'hB7);
    xfer(8'hB7, DW, mi);
    frame_end();
    chk("postreset_miso_word", 32'(mi), 32'h69);
    cyc(10);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
